imem_loader: RTL

Instruction-memory writer for the CPU core: accepts a framed byte stream and writes it into instruction memory as 32-bit big-endian words, at the addresses the fetch unit reads from. It holds the core in reset (`cpu_hold`) while loading and releases it only after a successful checksum. It sits between an external host byte source and the memory write port, beside `cpu_clock` and `fetch`.

---
 rtl/imem_loader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a length-prefixed byte frame, writes
// big-endian 32-bit words from ADDR_BASE upward, and holds the CPU until the checksum matches.
module imem_loader #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  state_t      r_state;
  state_t      w_next;
  logic        r_inReady;
  logic        r_memWe;
  logic [31:0] r_memAddr;
  logic [31:0] r_memWdata;
  logic        r_cpuHold;
  logic        r_done;
  logic        r_error;
  logic [15:0] r_wordsLoaded;
  logic [31:0] r_addr;
  logic [15:0] r_len;
  logic [23:0] r_asm;
  logic [1:0]  r_byteCnt;
  logic [7:0]  r_sum;

  logic        w_accept;
  logic [15:0] w_lenFull;
  logic [31:0] w_word;
  logic        w_lastWord;
  logic        w_nextActive;

  assign w_accept   = in_valid && r_inReady;
  assign w_lenFull  = {r_len[15:8], in_byte};
  assign w_word     = {r_asm, in_byte};
  assign w_lastWord = (r_byteCnt == 2'd3) && ((r_wordsLoaded + 16'd1) == r_len);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (start) w_next = S_LEN_HI;
      S_LEN_HI: if (w_accept) w_next = S_LEN_LO;
      S_LEN_LO: begin
        if (w_accept) begin
          if ({1'b0, w_lenFull} > MAX_LEN) w_next = S_ERR;
          else if (w_lenFull == 16'd0)     w_next = S_CSUM;
          else                             w_next = S_DATA;
        end
      end
      S_DATA: if (w_accept && w_lastWord) w_next = S_CSUM;
      S_CSUM: if (w_accept) w_next = (in_byte == r_sum) ? S_DONE : S_ERR;
      default: w_next = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they change with it.
  assign w_nextActive = (w_next == S_LEN_HI) || (w_next == S_LEN_LO) ||
                        (w_next == S_DATA)   || (w_next == S_CSUM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_inReady     <= 1'b0;
      r_memWe       <= 1'b0;
      r_memAddr     <= 32'd0;
      r_memWdata    <= 32'd0;
      r_cpuHold     <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_wordsLoaded <= 16'd0;
      r_addr        <= 32'd0;
      r_len         <= 16'd0;
      r_asm         <= 24'd0;
      r_byteCnt     <= 2'd0;
      r_sum         <= 8'd0;
    end else begin
      r_state   <= w_next;
      r_inReady <= w_nextActive;
      r_cpuHold <= (w_next != S_IDLE) && (w_next != S_DONE);
      r_done    <= (w_next == S_DONE);
      r_error   <= (w_next == S_ERR);
      r_memWe   <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_addr        <= ADDR_BASE;
            r_wordsLoaded <= 16'd0;
            r_sum         <= 8'd0;
            r_byteCnt     <= 2'd0;
            r_asm         <= 24'd0;
          end
        end
        S_LEN_HI: if (w_accept) r_len[15:8] <= in_byte;
        S_LEN_LO: if (w_accept) r_len <= w_lenFull;
        S_DATA: begin
          if (w_accept) begin
            r_asm     <= w_word[23:0];
            r_sum     <= r_sum + in_byte;
            r_byteCnt <= r_byteCnt + 2'd1;
            if (r_byteCnt == 2'd3) begin
              r_memWe       <= 1'b1;
              r_memAddr     <= r_addr;
              r_memWdata    <= w_word;
              r_addr        <= r_addr + 32'd4;
              r_wordsLoaded <= r_wordsLoaded + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready     = r_inReady;
  assign mem_we       = r_memWe;
  assign mem_addr     = r_memAddr;
  assign mem_wdata    = r_memWdata;
  assign cpu_hold     = r_cpuHold;
  assign done         = r_done;
  assign error        = r_error;
  assign words_loaded = r_wordsLoaded;

endmodule
